// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte-stream requesters.
// Each message is locked to one owner, prefixed with a source header and aborted on stall.
module uart_tx_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter logic [7:0] HDR_BASE     = 8'hA0,
  parameter int         TIMEOUT_CLKS = 65535
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Busy,
  output logic                 o_Msg_Done,
  output logic                 o_Abort
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_TX, FETCH} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_prio;
  logic [IDX_W-1:0]   r_grant_idx;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;

  logic [IDX_W:0]     pick;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_byte;
  logic               stall_expired;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // Returns {found, index}: first valid requester scanning upward from prio.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDX_W-1:0]   prio);
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] idx;
    logic             found;
    k     = prio;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[k]) begin
        found = 1'b1;
        idx   = k;
      end
      k = wrap_inc(k);
    end
    return {found, idx};
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] idx);
    return HDR_BASE + 8'(idx);
  endfunction

  assign pick          = rr_pick(i_Req_Valid, r_prio);
  assign pick_found    = pick[IDX_W];
  assign pick_idx      = pick[IDX_W-1:0];
  assign pick_oh       = NUM_REQ'(1) << pick_idx;
  assign stall_expired = (TIMEOUT_CLKS != 0) && (r_cnt == CNT_W'(TIMEOUT_CLKS - 1));

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_byte  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant_idx == IDX_W'(k)) begin
        sel_valid = i_Req_Valid[k];
        sel_last  = i_Req_Last[k];
        sel_byte  = i_Req_Byte[8*k +: 8];
      end
    end
  end

  assign o_Req_Ready = (r_state == FETCH) ? o_Grant : '0;
  assign o_Busy      = (r_state != IDLE);

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      r_state    <= IDLE;
      r_prio     <= '0;
      r_cnt      <= '0;
      o_TX_DV    <= 1'b0;
      o_TX_Byte  <= 8'h00;
      o_Grant    <= '0;
      o_Msg_Done <= 1'b0;
      o_Abort    <= 1'b0;
    end else begin
      o_TX_DV    <= 1'b0;
      o_Msg_Done <= 1'b0;
      o_Abort    <= 1'b0;
      case (r_state)
        IDLE: begin
          // UART_TX is not reset with us, so a frame may still be draining.
          if (pick_found && !i_TX_Active) begin
            r_grant_idx <= pick_idx;
            o_Grant     <= pick_oh;
            o_TX_DV     <= 1'b1;
            o_TX_Byte   <= hdr_byte(pick_idx);
            r_last      <= 1'b0;
            r_state     <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (i_TX_Done) begin
            if (r_last) begin
              o_Msg_Done <= 1'b1;
              r_prio     <= wrap_inc(r_grant_idx);
              o_Grant    <= '0;
              r_state    <= IDLE;
            end else begin
              r_cnt   <= '0;
              r_state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (sel_valid) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= sel_byte;
            r_last    <= sel_last;
            r_state   <= WAIT_TX;
          end else if (stall_expired) begin
            o_Abort <= 1'b1;
            r_prio  <= wrap_inc(r_grant_idx);
            o_Grant <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART_TX and queued requesters.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int FRAME = 4;

  logic              clk = 1'b0;
  logic              i_Rst;
  logic [NREQ-1:0]   i_Req_Valid;
  logic [8*NREQ-1:0] i_Req_Byte;
  logic [NREQ-1:0]   i_Req_Last;
  logic [NREQ-1:0]   o_Req_Ready;
  logic              o_TX_DV;
  logic [7:0]        o_TX_Byte;
  logic              i_TX_Active;
  logic              i_TX_Done;
  logic [NREQ-1:0]   o_Grant;
  logic              o_Busy;
  logic              o_Msg_Done;
  logic              o_Abort;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .HDR_BASE(8'hA0), .TIMEOUT_CLKS(16)) dut (
    .i_Clock(clk), .i_Rst(i_Rst),
    .i_Req_Valid(i_Req_Valid), .i_Req_Byte(i_Req_Byte), .i_Req_Last(i_Req_Last),
    .o_Req_Ready(o_Req_Ready), .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
    .i_TX_Active(i_TX_Active), .i_TX_Done(i_TX_Done), .o_Grant(o_Grant),
    .o_Busy(o_Busy), .o_Msg_Done(o_Msg_Done), .o_Abort(o_Abort)
  );

  // Requester queues: bench pushes at tail, consumer advances head on handshake.
  logic [7:0] rbyte [NREQ][64];
  logic       rlast [NREQ][64];
  logic [5:0] rhead [NREQ];
  logic [5:0] rtail [NREQ];
  logic       en    [NREQ];

  logic [7:0] cap [256];
  int         gap [256];
  int         ncap, msg_cnt, abort_cnt, lock_viol, ovl_viol, rdy3_cnt;
  int         neg_idx, done_idx, frame_left;
  int         n_tests, n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) rhead[k] = '0;
    forever begin
      @(posedge clk);
      for (int k = 0; k < NREQ; k++)
        if (i_Req_Valid[k] && o_Req_Ready[k] && !i_Rst) rhead[k] = rhead[k] + 6'd1;
    end
  end

  initial begin
    i_Req_Valid = '0;
    i_Req_Byte  = '0;
    i_Req_Last  = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) begin
        i_Req_Valid[k]       = en[k] && (rhead[k] != rtail[k]);
        i_Req_Byte[8*k +: 8] = rbyte[k][rhead[k]];
        i_Req_Last[k]        = rlast[k][rhead[k]];
      end
    end
  end

  // UART_TX model plus output monitors, all sampled on the falling edge.
  initial begin
    i_TX_Active = 1'b0; i_TX_Done = 1'b0;
    ncap = 0; msg_cnt = 0; abort_cnt = 0; lock_viol = 0; ovl_viol = 0; rdy3_cnt = 0;
    neg_idx = 0; done_idx = 0; frame_left = 0;
    forever begin
      @(negedge clk);
      neg_idx++;
      if (o_Msg_Done) msg_cnt++;
      if (o_Abort) abort_cnt++;
      if (o_Req_Ready != '0 && o_Req_Ready != o_Grant) lock_viol++;
      if (o_Req_Ready[3]) rdy3_cnt++;
      i_TX_Done = 1'b0;
      if (o_TX_DV) begin
        if (i_TX_Active) ovl_viol++;
        cap[ncap] = o_TX_Byte;
        gap[ncap] = neg_idx - done_idx;
        ncap++;
        i_TX_Active = 1'b1;
        frame_left  = FRAME;
      end else if (i_TX_Active) begin
        frame_left--;
        if (frame_left == 0) begin
          i_TX_Done   = 1'b1;
          i_TX_Active = 1'b0;
          done_idx    = neg_idx;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] b, input logic last);
    rbyte[k][rtail[k]] = b;
    rlast[k][rtail[k]] = last;
    rtail[k] = rtail[k] + 6'd1;
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    tick(); tick();
    i_Rst = 1'b0;
  endtask

  task automatic wait_msgs(input int target, input string tag);
    int i;
    i = 0;
    while (msg_cnt < target && i < 400) begin tick(); i++; end
    check_eq(tag, 32'(msg_cnt), 32'(target));
  endtask

  task automatic wait_cap(input int target, input string tag);
    int i;
    i = 0;
    while (ncap < target && i < 400) begin tick(); i++; end
    check_eq(tag, 32'(ncap), 32'(target));
  endtask

  task automatic expect_bytes(input string tag, input int base, input logic [7:0] e [], input int n);
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s_b%0d", tag, i), 32'(cap[base + i]), 32'(e[i]));
  endtask

  initial begin
    int base, mbase, abase, rbase, obase, i;
    logic [7:0] e [];
    n_tests = 0; n_fail = 0;
    for (int k = 0; k < NREQ; k++) begin rtail[k] = '0; en[k] = 1'b0; end
    i_Rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_dv",    32'(o_TX_DV),     0);
    check_eq("rst_byte",  32'(o_TX_Byte),   0);
    check_eq("rst_grant", 32'(o_Grant),     0);
    check_eq("rst_busy",  32'(o_Busy),      0);
    check_eq("rst_done",  32'(o_Msg_Done),  0);
    check_eq("rst_abort", 32'(o_Abort),     0);
    check_eq("rst_ready", 32'(o_Req_Ready), 0);
    i_Rst = 1'b0;
    tick();

    // Single message from requester 1
    base = ncap; mbase = msg_cnt;
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b1);
    en[1] = 1'b1;
    tick(); tick();
    check_eq("t1_hdr_dv",   32'(o_TX_DV),   1);
    check_eq("t1_hdr_byte", 32'(o_TX_Byte), 32'h A1);
    check_eq("t1_grant_a",  32'(o_Grant),   32'b0010);
    check_eq("t1_busy",     32'(o_Busy),    1);
    tick();
    check_eq("t1_dv_pulse", 32'(o_TX_DV),   0);
    check_eq("t1_grant_b",  32'(o_Grant),   32'b0010);
    wait_msgs(mbase + 1, "t1_msgs");
    check_eq("t1_grant_end", 32'(o_Grant), 0);
    check_eq("t1_busy_end",  32'(o_Busy),  0);
    tick();
    check_eq("t1_done_pulse", 32'(msg_cnt), 32'(mbase + 1));
    check_eq("t1_nbytes", 32'(ncap - base), 3);
    e = '{8'hA1, 8'h11, 8'h22};
    expect_bytes("t1", base, e, 3);
    check_eq("t1_gap1", 32'(gap[base + 1]), 2);
    check_eq("t1_gap2", 32'(gap[base + 2]), 2);
    en[1] = 1'b0;

    // Contention, then rotated priority (req3 ahead of req0)
    do_reset();
    base = ncap; mbase = msg_cnt;
    push(0, 8'h55, 1'b1); push(2, 8'h66, 1'b1);
    en[0] = 1'b1; en[2] = 1'b1;
    wait_msgs(mbase + 2, "t2_msgs");
    push(0, 8'h77, 1'b1); push(3, 8'h88, 1'b1);
    en[3] = 1'b1;
    wait_msgs(mbase + 4, "t2_msgs_rot");
    e = '{8'hA0, 8'h55, 8'hA2, 8'h66, 8'hA3, 8'h88, 8'hA0, 8'h77};
    expect_bytes("t2", base, e, 8);
    for (int k = 0; k < NREQ; k++) en[k] = 1'b0;

    // Fairness between two streaming requesters
    do_reset();
    base = ncap; mbase = msg_cnt;
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1); push(1, 8'h13, 1'b0); push(1, 8'h14, 1'b1);
    en[0] = 1'b1; en[1] = 1'b1;
    wait_msgs(mbase + 4, "t3_msgs");
    e = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12, 8'hA0, 8'h03, 8'h04, 8'hA1, 8'h13, 8'h14};
    expect_bytes("t3", base, e, 12);
    en[0] = 1'b0; en[1] = 1'b0;

    // Stall timeout on requester 3
    do_reset();
    base = ncap; abase = abort_cnt; rbase = rdy3_cnt;
    push(3, 8'h33, 1'b0);
    en[3] = 1'b1;
    wait_cap(base + 1, "t4_hdr");
    en[3] = 1'b0;
    i = 0;
    while (abort_cnt == abase && i < 200) begin tick(); i++; end
    check_eq("t4_abort",       32'(abort_cnt - abase), 1);
    check_eq("t4_fetch_cyc",   32'(rdy3_cnt - rbase),  16);
    check_eq("t4_grant_rel",   32'(o_Grant), 0);
    check_eq("t4_busy_rel",    32'(o_Busy),  0);
    tick();
    check_eq("t4_abort_pulse", 32'(abort_cnt - abase), 1);
    check_eq("t4_nbytes",      32'(ncap - base), 1);
    check_eq("t4_cap_hdr",     32'(cap[base]), 32'h A3);
    rtail[3] = rhead[3];
    base = ncap; mbase = msg_cnt;
    push(0, 8'h5A, 1'b1); push(3, 8'h3C, 1'b1);
    en[0] = 1'b1; en[3] = 1'b1;
    wait_msgs(mbase + 2, "t4_msgs");
    e = '{8'hA0, 8'h5A, 8'hA3, 8'h3C};
    expect_bytes("t4", base, e, 4);
    en[0] = 1'b0; en[3] = 1'b0;

    // Lock: requester 0 waits for requester 2 to finish
    do_reset();
    base = ncap; mbase = msg_cnt; obase = lock_viol;
    push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
    en[2] = 1'b1;
    wait_cap(base + 1, "t5_hdr");
    push(0, 8'h01, 1'b1);
    en[0] = 1'b1;
    wait_msgs(mbase + 2, "t5_msgs");
    e = '{8'hA2, 8'h21, 8'h22, 8'h23, 8'hA0, 8'h01};
    expect_bytes("t5", base, e, 6);
    check_eq("t5_lock_viol", 32'(lock_viol - obase), 0);
    en[0] = 1'b0; en[2] = 1'b0;

    // Reset while the UART is mid-frame
    do_reset();
    base = ncap; mbase = msg_cnt; obase = ovl_viol;
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b1);
    en[1] = 1'b1;
    wait_cap(base + 1, "t6_hdr");
    tick();
    i_Rst = 1'b1;
    tick();
    check_eq("t6_rst_dv",    32'(o_TX_DV),     0);
    check_eq("t6_rst_byte",  32'(o_TX_Byte),   0);
    check_eq("t6_rst_grant", 32'(o_Grant),     0);
    check_eq("t6_rst_busy",  32'(o_Busy),      0);
    check_eq("t6_rst_ready", 32'(o_Req_Ready), 0);
    check_eq("t6_rst_done",  32'(o_Msg_Done),  0);
    check_eq("t6_rst_abort", 32'(o_Abort),     0);
    i_Rst = 1'b0;
    tick();
    check_eq("t6_hold_busy", 32'(o_Busy), 0);
    wait_msgs(mbase + 1, "t6_msgs");
    e = '{8'hA1, 8'hA1, 8'h11, 8'h22};
    expect_bytes("t6", base, e, 4);
    check_eq("t6_overlap", 32'(ovl_viol - obase), 0);
    check_eq("lock_viol_total", 32'(lock_viol), 0);
    en[1] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin message arbiter that shares one UART_TX serializer among NUM_REQ byte-stream requesters (mining cores, status reporter, debug port). It locks the UART to one requester for a whole message, prefixes each message with a header byte identifying the source, and feeds bytes one at a time using UART_TX's data-valid/done handshake. A per-message stall timeout keeps a hung requester from holding the UART.

## Interface
- NUM_REQ, 4: number of requesters (2–8).
- HDR_BASE, 8'hA0: header byte = HDR_BASE + granted index.
- TIMEOUT_CLKS, 65535: max FETCH cycles without i_Req_Valid before abort; 0 disables.
- i_Clock  in  1  single clock; all logic on rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Req_Valid  in  NUM_REQ  per-requester byte valid.
- i_Req_Byte  in  8*NUM_REQ  per-requester byte, requester k at [8k+7:8k].
- i_Req_Last  in  NUM_REQ  marks final byte of a message.
- o_Req_Ready  out  NUM_REQ  one-hot; byte taken when valid&ready.
- o_TX_DV  out  1  one-cycle start pulse to UART_TX.
- o_TX_Byte  out  8  byte to UART_TX, valid with o_TX_DV.
- i_TX_Active  in  1  UART_TX busy.
- i_TX_Done  in  1  UART_TX one-cycle completion pulse.
- o_Grant  out  NUM_REQ  one-hot owner, zero when idle.
- o_Busy  out  1  message in progress.
- o_Msg_Done  out  1  one-cycle pulse, message fully sent.
- o_Abort  out  1  one-cycle pulse, message dropped by timeout.

## Operation
- States: IDLE, WAIT_TX, FETCH.
- IDLE: if any i_Req_Valid and i_TX_Active==0: pick first valid index scanning r_Prio, r_Prio+1, … mod NUM_REQ; latch grant; o_TX_DV<=1, o_TX_Byte<=HDR_BASE+grant; r_Last<=0; go WAIT_TX. Requester's first byte is not consumed here.
- WAIT_TX: o_TX_DV<=0. On i_TX_Done: if r_Last → o_Msg_Done<=1, r_Prio<=grant+1 mod NUM_REQ, grant cleared, IDLE; else → FETCH, timeout counter<=0.
- FETCH: o_Req_Ready[grant]=1 (combinational from state/grant), others 0. On i_Req_Valid[grant]: o_TX_DV<=1, o_TX_Byte<=byte, r_Last<=i_Req_Last[grant], WAIT_TX. Otherwise counter++; when counter reaches TIMEOUT_CLKS-1 (TIMEOUT_CLKS≠0): o_Abort<=1, r_Prio<=grant+1, IDLE. Requester must restart the message after abort.
- Valid from non-granted requesters ignored while locked; their ready stays 0.
- i_TX_Done outside WAIT_TX ignored.
- Header index arithmetic: 8-bit add, wraps modulo 256.
- Reset: state IDLE, r_Prio=0, counter=0; o_TX_DV=0, o_TX_Byte=8'h00, o_Grant=0, o_Busy=0, o_Msg_Done=0, o_Abort=0, o_Req_Ready=0.
- Reset mid-message: message discarded; UART_TX is not reset by this block, so IDLE waits for i_TX_Active==0 before the next grant.

## Timing
- Valid sampled in IDLE at edge N → o_TX_DV high during cycle N+1, exactly one cycle.
- i_TX_Done seen at edge M (not last) → FETCH during cycle M+1; if valid then, o_TX_DV high in cycle M+2. Gap between UART frames is 2 cycles with requester data ready.
- o_Busy = (state≠IDLE); o_Grant valid from cycle N+1 until cycle after final i_TX_Done.
- o_Msg_Done/o_Abort registered, high in the cycle after the causing event.
- Header + k data bytes = k+1 UART frames per message; 1-byte message (first byte has Last) = 2 frames.
- Simultaneous i_Rst with anything: reset wins.

## Test plan
- Single msg: req1 sends 8'h11, 8'h22(Last) → UART bytes A1, 11, 22; one o_Msg_Done; o_Grant=4'b0010 throughout.
- Contention: req0,req2 valid same cycle after reset → req0 served first (header A0), then req2 (A2); r_Prio=3 after.
- Fairness: req0 and req1 continuously streaming 2-byte messages → headers alternate A0, A1, A0, A1.
- Stall/timeout: TIMEOUT_CLKS=16, req3 sends header then drops valid → o_Abort exactly 16 FETCH cycles later, grant released, req0 then served.
- Lock: req2 mid-message, req0 raises valid → o_Req_Ready[0]=0 until req2 Last byte completes.
- Reset mid-frame: assert i_Rst while UART active → all outputs reset values; next grant waits until i_TX_Active falls.
